// File: rtl/cmp_pkg.sv
// Shared types and constants for the comparator peak tracker.
//   peak_state_t : window FSM states
//   CMP_DW       : comparator result width, default data width
package cmp_pkg;

  localparam int unsigned CMP_DW = 4;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } peak_state_t;

endpackage

// File: rtl/cmp_peak_tracker_if.sv
// Handshake bundle for the peak tracker.
//   in_valid/in_ready/in_data : comparator sample stream
//   flush                     : close the current window early
//   out_valid/out_ready       : window result handshake
//   out_peak/out_count/out_rises : window result fields
// master = producer/consumer side, slave = tracker side.
interface cmp_peak_tracker_if
  import cmp_pkg::*;
#(
  parameter int unsigned DW  = CMP_DW,
  parameter int unsigned WIN = 8,
  parameter int unsigned CW  = $clog2(WIN + 1)
);

  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          flush;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_peak;
  logic [CW-1:0] out_count;
  logic [CW-1:0] out_rises;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_peak, out_count, out_rises
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_peak, out_count, out_rises
  );

endinterface

// File: rtl/cmp_peak_tracker_gt.sv
// Unsigned greater-than comparator.
//   a, b : operands (DW bits, unsigned)
//   gt   : 1 when a > b
module peak_gt #(
  parameter int unsigned DW = 4
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          gt
);

  always_comb gt = (a > b);

endmodule

// File: rtl/cmp_peak_tracker.sv
// Windowed running-maximum tracker over the comparator result stream.
// Counts samples and peak increases per window of WIN samples (or until
// flush), then holds the result on a valid/ready output.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of cmp_peak_tracker_if (sample in, result out)
module cmp_peak_tracker
  import cmp_pkg::*;
#(
  parameter int unsigned DW  = CMP_DW,
  parameter int unsigned WIN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  cmp_peak_tracker_if.slave   bus
);

  localparam int unsigned CW = $clog2(WIN + 1);

  peak_state_t   state, state_nxt;
  logic [DW-1:0] peak, peak_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [CW-1:0] rises, rises_nxt;
  logic          accept, start, cont, close, gt;

  peak_gt #(.DW(DW)) u_gt (
    .a  (bus.in_data),
    .b  (peak),
    .gt (gt)
  );

  // An accept outside ACCUM always opens a new window; in HOLD an accept
  // implies out_ready, so it is also the release of the held result.
  always_comb begin
    accept    = bus.in_valid & bus.in_ready;
    start     = accept & (state != ACCUM);
    cont      = accept & (state == ACCUM);
    peak_nxt  = peak;
    cnt_nxt   = cnt;
    rises_nxt = rises;
    if (start) begin
      peak_nxt  = bus.in_data;
      cnt_nxt   = CW'(1);
      rises_nxt = '0;
    end else if (cont) begin
      cnt_nxt = cnt + CW'(1);
      if (gt) begin
        peak_nxt  = bus.in_data;
        rises_nxt = rises + CW'(1);
      end
    end
    // WIN >= 2, so a first sample can only close the window via flush.
    close = (start & bus.flush)
          | (cont & (bus.flush | (cnt_nxt == CW'(WIN))))
          | ((state == ACCUM) & ~accept & bus.flush);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (close)
      state_nxt = HOLD;
    else if (accept)
      state_nxt = ACCUM;
    else if ((state == HOLD) && bus.out_ready)
      state_nxt = IDLE;
  end

  always_comb begin
    bus.in_ready  = (state != HOLD) | bus.out_ready;
    bus.out_valid = (state == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak  <= '0;
      cnt   <= '0;
      rises <= '0;
    end else begin
      peak  <= peak_nxt;
      cnt   <= cnt_nxt;
      rises <= rises_nxt;
    end
  end

  // Result registers change only on entry to HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_peak  <= '0;
      bus.out_count <= '0;
      bus.out_rises <= '0;
    end else if (close) begin
      bus.out_peak  <= peak_nxt;
      bus.out_count <= cnt_nxt;
      bus.out_rises <= rises_nxt;
    end
  end

endmodule

// File: tb/tb_cmp_peak_tracker.sv
// Directed self-checking bench for cmp_peak_tracker (DW=4, WIN=8).
module tb_cmp_peak_tracker;

  localparam int unsigned DW  = 4;
  localparam int unsigned WIN = 8;

  logic clk;
  logic rst_n;
  int   tests;
  int   failed;
  int   results;

  cmp_peak_tracker_if #(.DW(DW), .WIN(WIN)) bus ();

  cmp_peak_tracker #(.DW(DW), .WIN(WIN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int pk,
                         input int cn, input int rs);
    chk({tag, ".out_valid"}, int'(bus.out_valid), v);
    chk({tag, ".out_peak"},  int'(bus.out_peak),  pk);
    chk({tag, ".out_count"}, int'(bus.out_count), cn);
    chk({tag, ".out_rises"}, int'(bus.out_rises), rs);
  endtask

  // Drive inputs, let one rising edge pass, return 1 time unit after it.
  task automatic step(input logic v, input int d, input logic f, input logic r);
    bus.in_valid  = v;
    bus.in_data   = DW'(d);
    bus.flush     = f;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int full_win [8] = '{3, 1, 7, 7, 2, 9, 4, 5};
    tests   = 0;
    failed  = 0;
    results = 0;
    rst_n   = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;

    // Reset and idle
    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready", int'(bus.in_ready), 1);
    chk_out("rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    step(1'b0, 0, 1'b0, 1'b0);
    step(1'b0, 0, 1'b0, 1'b0);
    chk("idle.in_ready", int'(bus.in_ready), 1);
    chk_out("idle", 0, 0, 0, 0);

    // Full window
    for (int i = 0; i < 8; i++) begin
      step(1'b1, full_win[i], 1'b0, 1'b1);
      if (i < 7) chk("full.early_valid", int'(bus.out_valid), 0);
    end
    chk_out("full", 1, 9, 8, 2);
    step(1'b0, 0, 1'b0, 1'b1);
    chk_out("full.release", 0, 9, 8, 2);

    // Early flush, then flush alone in IDLE
    step(1'b1, 4, 1'b0, 1'b1);
    chk("flush.first_valid", int'(bus.out_valid), 0);
    step(1'b1, 6, 1'b1, 1'b1);
    chk_out("flush", 1, 6, 2, 1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("flush.release", int'(bus.out_valid), 0);
    step(1'b0, 0, 1'b1, 1'b1);
    chk_out("idle_flush", 0, 6, 2, 1);
    step(1'b0, 0, 1'b0, 1'b1);
    chk("idle_flush.after", int'(bus.out_valid), 0);

    // Backpressure
    for (int i = 0; i < 8; i++) step(1'b1, 5, 1'b0, 1'b0);
    chk_out("bp.hold", 1, 5, 8, 0);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = 4'd7;
      bus.out_ready = 1'b0;
      #1;
      chk("bp.in_ready_low", int'(bus.in_ready), 0);
      step(1'b1, 7, 1'b0, 1'b0);
      chk_out("bp.stable", 1, 5, 8, 0);
    end
    bus.out_ready = 1'b1;
    bus.in_data   = 4'd2;
    #1;
    chk("bp.in_ready_high", int'(bus.in_ready), 1);
    step(1'b1, 2, 1'b0, 1'b1);
    chk("bp.new_window", int'(bus.out_valid), 0);
    step(1'b1, 1, 1'b1, 1'b1);
    chk_out("bp.next", 1, 2, 2, 0);
    step(1'b0, 0, 1'b0, 1'b1);

    // Back-to-back: windows 0..7, 1..8, 2..9
    for (int i = 0; i < 24; i++) begin
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("b2b.in_ready", int'(bus.in_ready), 1);
      step(1'b1, (i % 8) + (i / 8), 1'b0, 1'b1);
      chk("b2b.valid", int'(bus.out_valid), ((i % 8) == 7) ? 1 : 0);
      if (bus.out_valid) begin
        results++;
        chk("b2b.count", int'(bus.out_count), 8);
        chk("b2b.peak",  int'(bus.out_peak),  7 + (i / 8));
        chk("b2b.rises", int'(bus.out_rises), 7);
      end
    end
    step(1'b0, 0, 1'b0, 1'b1);
    chk("b2b.results", results, 3);
    chk("b2b.drained", int'(bus.out_valid), 0);

    // Reset mid-window
    for (int i = 0; i < 5; i++) step(1'b1, 15, 1'b0, 1'b1);
    bus.in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst.in_ready", int'(bus.in_ready), 1);
    chk_out("midrst", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i + 1, 1'b0, 1'b1);
      if (i < 7) chk("midrst.early_valid", int'(bus.out_valid), 0);
    end
    chk_out("midrst.fresh", 1, 8, 8, 7);
    step(1'b0, 0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cmp_peak_tracker.md
# cmp_peak_tracker

Streaming peak detector that sits directly downstream of the 4-bit magnitude comparator and consumes its result stream one sample per accepted handshake. It tracks the running maximum over a window of WIN accepted samples, or fewer if the window is closed early by `flush`. It also counts how many times the peak increased, then presents the result on a valid/ready output until the consumer takes it.

## Interface
- `DW`, 4: data width of comparator result samples; unsigned.
- `WIN`, 8: samples per window; legal range 2..255.
- `CW`, `$clog2(WIN+1)`: count width; derived, not overridden.

- `clk` in 1: single clock; all state on rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low; release is synchronous to `clk` upstream.
- `in_valid` in 1: comparator sample valid.
- `in_ready` out 1: block accepts sample this cycle.
- `in_data` in DW: comparator result (unsigned).
- `flush` in 1: close current window early; single-cycle pulse.
- `out_valid` out 1: window result available.
- `out_ready` in 1: consumer takes result.
- `out_peak` out DW: maximum sample of the window.
- `out_count` out CW: samples in the window, 1..WIN.
- `out_rises` out CW: number of accepted samples strictly greater than the running peak (first sample excluded).

## Operation
- Accept = `in_valid & in_ready`. Release = `out_valid & out_ready`.
- FSM states IDLE, ACCUM, HOLD. Reset state is IDLE.
- `in_ready` = (state != HOLD) | `out_ready`.
- `out_valid` = (state == HOLD).
- IDLE:
  - On accept: peak <= `in_data`, cnt <= 1, rises <= 0, go to ACCUM.
  - If `flush` is also asserted, go to HOLD with cnt=1.
  - `flush` without accept: ignored.
- ACCUM:
  - On accept: cnt <= cnt+1.
  - If `in_data` > peak: peak <= `in_data` and rises <= rises+1.
  - Equal samples do not count as rises.
  - Go to HOLD when cnt+1 == WIN, or when `flush` is asserted in the same cycle.
  - `flush` without accept: go to HOLD with current values.
- HOLD:
  - `out_peak`, `out_count` and `out_rises` are stable and `in_ready`=0 until release.
  - On release without accept: go to IDLE.
  - On release with accept: start a new window as from IDLE, honouring `flush` identically.
  - `flush` while in HOLD without a simultaneous accept: ignored (not queued).
- Comparison is unsigned, DW bits. No saturation is needed because cnt ≤ WIN fits CW.

## Timing
- Reset: state IDLE; `in_ready`=1, `out_valid`=0, `out_peak`=0, `out_count`=0, `out_rises`=0; internal peak/cnt/rises are 0.
- Latency: the window-closing accept (or flush) in cycle t gives `out_valid`=1 in cycle t+1, with registered outputs.
- Throughput: one sample per cycle sustained, with zero bubbles between windows when `out_ready` is held high.
- Output registers load only on entry to HOLD. They hold their value in IDLE/ACCUM, with `out_valid` low.
- Reset asserted mid-window or in HOLD: immediate return to reset values. The partial window is discarded and no result is emitted.
- `in_data` is sampled only on accept. `out_ready` is ignored outside HOLD.

## Structure
- Package `cmp_pkg`:
  - state enum `peak_state_t` {IDLE, ACCUM, HOLD};
  - localparam `CMP_DW` = 4, which is the default for `DW`.
- One combinational sub-module, `peak_gt`: parameterised DW, outputs `gt` = a > b, unsigned. It drives both the peak update and the rise count.
- Top module: FSM, counters, output registers.

## Test plan
- Reset and idle: hold `rst_n`=0 then release, no input -> `in_ready`=1, `out_valid`=0, all outputs 0.
- Full window, WIN=8, `out_ready`=1, samples 3,1,7,7,2,9,4,5 -> one cycle after the 8th accept: `out_peak`=9, `out_count`=8, `out_rises`=2.
- Early flush: samples 4,6 with `flush` on the 2nd accept -> `out_peak`=6, `out_count`=2, `out_rises`=1. Next, flush in IDLE alone -> no output.
- Backpressure: `out_ready`=0 during HOLD -> `in_ready`=0 and outputs stable for 5 cycles. When `out_ready` rises with `in_valid`=1 and data 2, the new window starts with peak=2, cnt=1 and no lost cycle.
- Back-to-back: 24 continuous samples with `out_ready`=1 -> exactly 3 results, each `out_count`=8, and `in_ready` never low.
- Reset mid-window: after 5 accepts assert `rst_n`=0 -> outputs 0 immediately. Then 8 fresh samples -> `out_count`=8, with no leakage from the prior window.
